uart_debug_trace: RTL and testbench

Parametrised on-chip event tracer for the UART datapath. It samples a vector of probe channels, for example `rxrdy`, `txrdy`, `framing_err`, `parity_err`, `overflow`, `wen`, `oen` and `csn`. After a masked rising-edge trigger it stores every change of the probe vector, with an inter-event cycle delta, into a circular RAM buffer. The stored trace is drained entry by entry through a simple read port, so UART faults can be captured on silicon without the JTAG debug core.

---
 rtl/uart_debug_trace.sv | 195 +++++++++++++++++++
 tb/tb_uart_debug_trace.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_trace.sv
// uart_debug_trace: on-chip event tracer for the UART datapath.
//
// Samples CH probe channels through two registers. After a masked rising-edge trigger it
// stores every change of the probe vector, tagged with the cycle delta since the previous
// stored entry, in a DEPTH-entry RAM. The trace is then drained in FIFO order via rd_en.
//
// Optional feature: define UART_DEBUG_TRACE_TIMESTAMP_EN to populate the delta field and
// write heartbeat entries when the delta saturates. Without it the delta field reads 0.
//
// Ports:
//   clk        design clock, rising edge
//   rst        synchronous active-high reset
//   probe      observed channels (already synchronous to clk)
//   trig_mask  channels whose rising edge starts capture
//   arm        pulse: IDLE -> ARMED
//   stop       pulse: disarm, end capture early, or discard the trace in DONE
//   rd_en      pop one entry (DONE only)
//   rd_data    popped entry {delta, probe_snapshot}, registered
//   rd_valid   one-cycle pulse qualifying rd_data
//   state      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   count      number of stored entries
module uart_debug_trace #(
    parameter int unsigned CH    = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH-1:0]            probe,
    input  logic [CH-1:0]            trig_mask,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_en,
    output logic [TS_W+CH-1:0]       rd_data,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = TS_W + CH;
    localparam logic [CW-1:0] LastFill = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CH-1:0]   p_q, p_qq;
    logic            chg, trg;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            we;
    logic            rd_fire;
    logic            hb;
    logic [TS_W-1:0] delta_field;
    logic [EW-1:0]   wr_data;
    logic [EW-1:0]   rd_data_q;
    logic            rd_valid_q;
    logic [EW-1:0]   mem [DEPTH];

    assign chg = (p_q != p_qq);
    assign trg = |(p_q & ~p_qq & trig_mask);

`ifdef UART_DEBUG_TRACE_TIMESTAMP_EN
    // delta_q counts cycles elapsed since the last written entry; every write reloads 1 so
    // that two changes on consecutive cycles record a delta of 1.
    logic [TS_W-1:0] delta_q, delta_d;

    assign hb          = (delta_q == '1);
    assign delta_field = delta_q;

    always_comb begin
        delta_d = delta_q;
        if (we) begin
            delta_d = TS_W'(1);
        end else if (state_q == StCapture) begin
            delta_d = delta_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
        end else begin
            delta_q <= delta_d;
        end
    end
`else
    assign hb          = 1'b0;
    assign delta_field = '0;
`endif

    // The trigger entry always carries a zero delta.
    assign wr_data = {(state_q == StArmed) ? {TS_W{1'b0}} : delta_field, p_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we       = 1'b0;
        rd_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d  = StArmed;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            StArmed: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (trg) begin
                    we       = 1'b1;
                    state_d  = StCapture;
                    count_d  = CW'(1);
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
            StCapture: begin
                if (chg || hb) begin
                    we       = 1'b1;
                    count_d  = count_q + CW'(1);
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q == LastFill) begin
                        state_d = StDone;
                    end
                end
                // A same-cycle event is still written; the buffer cannot be full here.
                if (stop) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (rd_en && (count_q != '0)) begin
                    rd_fire  = 1'b1;
                    count_d  = count_q - CW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            p_qq       <= '0;
            state_q    <= StIdle;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            p_q        <= probe;
            p_qq       <= p_q;
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Trace RAM: contents survive reset.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign count    = count_q;

endmodule

// File: tb/tb_uart_debug_trace.sv
// Testbench for uart_debug_trace (CH=8, DEPTH=16, TS_W=8). A trace model derived from the
// probe history predicts the stored entries; expected read data goes into a scoreboard queue
// that a negedge monitor pops whenever the read response is due.
module tb_uart_debug_trace;

    localparam int CH    = 8;
    localparam int DEPTH = 16;
    localparam int TS_W  = 8;
`ifdef UART_DEBUG_TRACE_TIMESTAMP_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   probe = '0;
    logic [CH-1:0]   trig_mask = '0;
    logic            arm = 1'b0;
    logic            stop = 1'b0;
    logic            rd_en = 1'b0;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic [1:0]      state;
    logic [4:0]      count;

    uart_debug_trace #(.CH(CH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .probe     (probe),
        .trig_mask (trig_mask),
        .arm       (arm),
        .stop      (stop),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .state     (state),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    exp_t        sb[$];
    logic [15:0] last_exp = '0;

    logic [7:0]  pseq [0:511];
    int          n_cur;
    logic [15:0] mdl[$];
    int          m_t, m_state, m_seff;
    bit          m_do_stop;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read-response monitor.
    always @(negedge clk) begin
        if (rst) begin
            last_exp = '0;
        end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(sb[0].data));
            last_exp = sb[0].data;
            void'(sb.pop_front());
        end else begin
            check("rd_valid_idle", 32'(rd_valid), 32'd0);
            check("rd_data_hold", 32'(rd_data), 32'(last_exp));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Probe value sampled at local edge i; held at the ends.
    function automatic logic [7:0] p_at(input int i);
        if (i < 0) return pseq[0];
        if (i >= n_cur) return pseq[n_cur-1];
        return pseq[i];
    endfunction

    // Trace model. Local edge 0 samples arm; a probe change between samples e-2 and e-1 is
    // acted on at edge e. Stop at edge m_seff (n when s<0) unless the buffer filled earlier.
    function automatic void build_model(input int n, input logic [7:0] mask, input int s);
        int last;
        int gap;
        n_cur     = n;
        m_seff    = (s < 0) ? n : s;
        m_t       = -1;
        m_do_stop = 1'b1;
        mdl.delete();
        for (int e = 1; e <= m_seff; e++) begin
            if ((p_at(e-1) & ~p_at(e-2) & mask) != 8'h00) begin
                if (e < m_seff) m_t = e;
                break;
            end
        end
        if (m_t < 0) begin
            m_state = 0;
            return;
        end
        mdl.push_back({8'd0, p_at(m_t-1)});
        last = m_t;
        for (int e = m_t + 1; e <= m_seff; e++) begin
            gap = e - last;
            if (p_at(e-1) != p_at(e-2) || (HB && gap == 255)) begin
                mdl.push_back({HB ? gap[7:0] : 8'd0, p_at(e-1)});
                last = e;
                if (mdl.size() == DEPTH) begin
                    if (e < m_seff) m_do_stop = 1'b0;
                    break;
                end
            end
        end
        m_state = 3;
    endfunction

    task automatic run_capture(input int n, input logic [7:0] mask, input int s);
        build_model(n, mask, s);
        trig_mask = mask;
        probe     = pseq[0];
        repeat (3) tick();
        for (int i = 0; i <= n; i++) begin
            probe = p_at(i);
            arm   = (i == 0);
            stop  = m_do_stop && (i == m_seff);
            tick();
            arm  = 1'b0;
            stop = 1'b0;
            @(negedge clk);
            if (i == 0) check("state_armed", 32'(state), 32'd1);
            if (i == m_t) begin
                check("state_capture", 32'(state), 32'd2);
                check("count_trigger", 32'(count), 32'd1);
            end
        end
        @(negedge clk);
        check("state_end", 32'(state), 32'(m_state));
        check("count_end", 32'(count), (m_state == 3) ? 32'(mdl.size()) : 32'd0);
    endtask

    // Pop nreads entries (all when negative), then stop-discard the rest if any remain.
    task automatic readout(input int nreads);
        int tot, lim, k;
        tot = mdl.size();
        lim = (nreads < 0 || nreads > tot) ? tot : nreads;
        k   = 0;
        if (m_state != 3) return;
        while (k < lim) begin
            if ($urandom_range(0, 2) == 0) begin
                rd_en = 1'b0;
            end else begin
                rd_en = 1'b1;
                sb.push_back('{due: edge_cnt + 1, data: mdl[k]});
                k++;
            end
            tick();
        end
        rd_en = 1'b0;
        repeat (2) tick();
        if (k < tot) begin
            @(negedge clk);
            check("count_partial", 32'(count), 32'(tot - k));
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        // rd_en in IDLE must be ignored.
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("state_idle", 32'(state), 32'd0);
        check("count_idle", 32'(count), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic fill_pattern();
        pseq[0] = 8'h00;
        pseq[1] = 8'h01;
        for (int i = 2; i < 32; i++) pseq[i] = (i % 2 == 0) ? 8'h03 : 8'h01;
    endtask

    initial begin
        // Reset values.
        repeat (3) tick();
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // Reset in CAPTURE with five stored entries.
        trig_mask = 8'h01;
        probe     = 8'h00;
        repeat (3) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        probe = 8'h01; tick();
        probe = 8'h03; tick();
        probe = 8'h01; tick();
        probe = 8'h03; tick();
        probe = 8'h01; tick();
        repeat (2) tick();
        @(negedge clk);
        check("pre_rst_state", 32'(state), 32'd2);
        check("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_data", 32'(rd_data), 32'd0);
        rst   = 1'b0;
        probe = 8'h00;
        tick();

        // Basic capture: 00->01 trigger, 01->03 five cycles later, then stop.
        for (int i = 0; i < 12; i++) pseq[i] = (i < 2) ? 8'h00 : (i < 7) ? 8'h01 : 8'h03;
        run_capture(12, 8'h01, 10);
        readout(-1);

        // Fill: toggle bit 1 every cycle after the trigger.
        fill_pattern();
        run_capture(32, 8'h01, -1);
        readout(-1);

        // Reuse after wrap: three new entries only.
        pseq[0] = 8'h00; pseq[1] = 8'h01; pseq[2] = 8'h03; pseq[3] = 8'h01;
        for (int i = 4; i < 12; i++) pseq[i] = 8'h01;
        run_capture(12, 8'h01, 10);
        readout(-1);

        // Fill, pop three, then stop in DONE with 13 left.
        fill_pattern();
        run_capture(32, 8'h01, -1);
        readout(3);

        // Heartbeat: hold 01 for 300 cycles after the trigger.
        pseq[0] = 8'h00;
        for (int i = 1; i < 302; i++) pseq[i] = 8'h01;
        run_capture(302, 8'h01, -1);
        readout(-1);

        // Stop in the same cycle as a masked rising edge.
        for (int i = 0; i < 6; i++) pseq[i] = (i < 2) ? 8'h00 : 8'h01;
        run_capture(6, 8'h01, 3);
        readout(-1);

        // Zero mask never triggers.
        for (int i = 0; i < 10; i++) pseq[i] = 8'(i * 37);
        run_capture(10, 8'h00, 8);
        readout(-1);

        // Randomised captures.
        for (int it = 0; it < 16; it++) begin
            int          n, s;
            logic [7:0]  mask;
            n       = $urandom_range(20, 60);
            s       = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(5, n - 1);
            mask    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            pseq[0] = 8'($urandom_range(0, 255));
            for (int i = 1; i < n; i++) begin
                pseq[i] = ($urandom_range(0, 2) == 0) ? pseq[i-1] ^ 8'($urandom_range(1, 255))
                                                      : pseq[i-1];
            end
            run_capture(n, mask, s);
            readout(($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, DEPTH - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
